// File: rtl/operand_fetch_pkg.sv
// Shared widths, state encoding and payload types for the operand fetch stage.
package operand_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 2 ** AW;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } of_state_e;

    typedef struct packed {
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          wen;
    } of_instr_t;

    // x0 reads as zero; a same-cycle writeback beats the stale regfile read
    function automatic logic [XLEN-1:0] resolve_operand(
        input logic [AW-1:0]   rs,
        input logic            byp,
        input logic [XLEN-1:0] byp_data,
        input logic [XLEN-1:0] rf_data
    );
        if (rs == REG_ZERO) return '0;
        if (byp)            return byp_data;
        return rf_data;
    endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write tracker: one busy bit per register, set beats clear, x0 never busy.
module operand_fetch_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_idx,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_idx,
    output logic [NREG-1:0] busy
);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (set_en && (set_idx == AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if (clr_en && (clr_idx == AW'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
            busy[0] <= 1'b0;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: hazard-checked issue of regfile reads, writeback bypass,
// and valid/ready hand-off of resolved operands to execute.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic            in_wen,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            rf_wr,
    output logic            rf_rd,
    output logic [AW-1:0]   rf_selwr,
    output logic [AW-1:0]   rf_selrd1,
    output logic [AW-1:0]   rf_selrd2,
    output logic [XLEN-1:0] rf_in,
    input  logic [XLEN-1:0] rf_out1,
    input  logic [XLEN-1:0] rf_out2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [AW-1:0]   out_rd,
    output logic            out_wen
);

    of_state_e       state;
    of_instr_t       instr_q;
    logic            byp1_q;
    logic            byp2_q;
    logic [XLEN-1:0] byp1_data_q;
    logic [XLEN-1:0] byp2_data_q;
    logic [NREG-1:0] busy;

    logic wb_hit1;
    logic wb_hit2;
    logic wb_hitd;
    logic hazard;
    logic accept;
    logic set_en;

    // A busy register released by this cycle's writeback does not stall
    always_comb begin
        wb_hit1 = wb_valid && (wb_rd == in_rs1);
        wb_hit2 = wb_valid && (wb_rd == in_rs2);
        wb_hitd = wb_valid && (wb_rd == in_rd);
        hazard  = (busy[in_rs1] && !wb_hit1)
               || (busy[in_rs2] && !wb_hit2)
               || (in_wen && busy[in_rd] && !wb_hitd);
        accept  = !rst && (state == IDLE) && in_valid && !hazard;
        set_en  = accept && in_wen && (in_rd != REG_ZERO);
    end

    assign in_ready  = accept;
    assign rf_rd     = accept;
    assign rf_selrd1 = accept ? in_rs1 : REG_ZERO;
    assign rf_selrd2 = accept ? in_rs2 : REG_ZERO;

    assign rf_wr    = !rst && wb_valid && (wb_rd != REG_ZERO);
    assign rf_selwr = wb_rd;
    assign rf_in    = wb_data;

    operand_fetch_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (set_en),
        .set_idx (in_rd),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd),
        .busy    (busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instr_q     <= '0;
            byp1_q      <= 1'b0;
            byp2_q      <= 1'b0;
            byp1_data_q <= '0;
            byp2_data_q <= '0;
            out_valid   <= 1'b0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_rd      <= '0;
            out_wen     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        instr_q     <= '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, wen: in_wen};
                        byp1_q      <= wb_hit1 && (in_rs1 != REG_ZERO);
                        byp2_q      <= wb_hit2 && (in_rs2 != REG_ZERO);
                        byp1_data_q <= wb_data;
                        byp2_data_q <= wb_data;
                        state       <= READ;
                    end
                end
                READ: begin
                    out_op1   <= resolve_operand(instr_q.rs1, byp1_q, byp1_data_q, rf_out1);
                    out_op2   <= resolve_operand(instr_q.rs2, byp2_q, byp2_data_q, rf_out2);
                    out_rd    <= instr_q.rd;
                    out_wen   <= instr_q.wen;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
